instr_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 68 ++++++
 rtl/instr_decode.sv | 85 ++++++++
 rtl/instr_sequencer.sv | 103 ++++++++++
 tb/tb_instr_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor control path.
// Holds the opcode map, instruction-field positions, FSM states,
// register-file write-source codes and ALU function codes.
package cpu_pkg;

  localparam int PC_W = 8;
  localparam int IW   = 19;

  // Instruction field positions: [18:15] op, [14:10] Rx, [9:5] Ry, [4:0] Rz
  localparam int OP_MSB  = 18;
  localparam int OP_LSB  = 15;
  localparam int RX_MSB  = 14;
  localparam int RX_LSB  = 10;
  localparam int RY_MSB  = 9;
  localparam int RY_LSB  = 5;
  localparam int RZ_MSB  = 4;
  localparam int RZ_LSB  = 0;
  localparam int IMM_MSB = 9;
  localparam int IMM_LSB = 2;
  // Jump encoding reuses the register fields: flag index and absolute target
  localparam int JK_MSB  = 14;
  localparam int JK_LSB  = 13;
  localparam int JT_MSB  = 12;
  localparam int JT_LSB  = 5;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_CMP  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_INC  = 4'b0011;
  localparam logic [3:0] OP_MOV  = 4'b0100;
  localparam logic [3:0] OP_LDM  = 4'b0101;
  localparam logic [3:0] OP_STM  = 4'b0110;
  localparam logic [3:0] OP_LDI  = 4'b0111;
  localparam logic [3:0] OP_JF0  = 4'b1000;
  localparam logic [3:0] OP_JF1  = 4'b1001;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MEM = 2'b01;
  localparam logic [1:0] WSEL_IMM = 2'b10;
  localparam logic [1:0] WSEL_RB  = 2'b11;

  localparam logic [1:0] FS_ADD = 2'b00;
  localparam logic [1:0] FS_CMP = 2'b01;
  localparam logic [1:0] FS_SUB = 2'b10;
  localparam logic [1:0] FS_INC = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_ALU,
    CL_CMP,
    CL_MOV,
    CL_LD,
    CL_JMP,
    CL_MEM_LD,
    CL_MEM_ST,
    CL_HLT,
    CL_NOP
  } iclass_e;

endpackage

// File: rtl/instr_decode.sv
// Purpose: combinational decode of the instruction register into datapath controls.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow ir_i and are qualified by the sequencer strobes.
// Ports: ir_i instruction word; ra_o/rb_o read addresses; wa_o write address;
//        wsel_o write source; alu_fs_o ALU function; imm_o LD immediate; class_o kind.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [IW-1:0] ir_i,
  output logic [4:0]    ra_o,
  output logic [4:0]    rb_o,
  output logic [4:0]    wa_o,
  output logic [1:0]    wsel_o,
  output logic [1:0]    alu_fs_o,
  output logic [7:0]    imm_o,
  output iclass_e       class_o
);

  logic [3:0] op;
  logic [4:0] rx;
  logic [4:0] ry;
  logic [4:0] rz;

  assign op    = ir_i[OP_MSB:OP_LSB];
  assign rx    = ir_i[RX_MSB:RX_LSB];
  assign ry    = ir_i[RY_MSB:RY_LSB];
  assign rz    = ir_i[RZ_MSB:RZ_LSB];
  assign imm_o = ir_i[IMM_MSB:IMM_LSB];

  always_comb begin
    ra_o     = '0;
    rb_o     = '0;
    wa_o     = '0;
    wsel_o   = WSEL_ALU;
    alu_fs_o = FS_ADD;
    class_o  = CL_NOP;
    case (op)
      OP_ADD, OP_SUB: begin
        ra_o     = ry;
        rb_o     = rz;
        wa_o     = rx;
        alu_fs_o = op[1:0];  // ADD/SUB encodings double as the ALU code
        class_o  = CL_ALU;
      end
      OP_CMP: begin
        ra_o     = rx;
        rb_o     = ry;
        alu_fs_o = FS_CMP;
        class_o  = CL_CMP;
      end
      OP_INC: begin
        ra_o     = rx;
        wa_o     = rx;
        alu_fs_o = FS_INC;
        class_o  = CL_ALU;
      end
      OP_MOV: begin
        rb_o    = rx;
        wa_o    = ry;
        wsel_o  = WSEL_RB;
        class_o = CL_MOV;
      end
      OP_LDI: begin
        wa_o    = rx;
        wsel_o  = WSEL_IMM;
        class_o = CL_LD;
      end
      OP_LDM: begin
        ra_o    = rx;  // address
        wa_o    = ry;
        wsel_o  = WSEL_MEM;
        class_o = CL_MEM_LD;
      end
      OP_STM: begin
        ra_o    = ry;  // address
        rb_o    = rx;  // data
        class_o = CL_MEM_ST;
      end
      OP_JF0, OP_JF1: class_o = CL_JMP;
      OP_HLT:         class_o = CL_HLT;
      default:        class_o = CL_NOP;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Purpose: multi-cycle fetch/decode/execute control unit; owns PC, IR and flags.
// Latency: 3 cycles per ALU/MOV/LD/jump/NOP, 4 per load/store, +1 per memory wait.
// Backpressure: holds imem_req/dmem_req high until the matching ack is sampled.
// Ports: imem_* fetch handshake; rf_* register-file controls; imm/alu_fs datapath
//        controls; alu_flag ALU status in; dmem_* data handshake; flags, halted status.
module instr_sequencer
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_data,
  output logic [4:0]      rf_ra,
  output logic [4:0]      rf_rb,
  output logic [4:0]      rf_wa,
  output logic            rf_we,
  output logic [1:0]      rf_wsel,
  output logic [7:0]      imm,
  output logic [1:0]      alu_fs,
  input  logic [3:0]      alu_flag,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic [3:0]      flags,
  output logic            halted
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [IW-1:0]   ir_q;
  logic [3:0]      f_q;

  iclass_e         dec_class;
  logic [1:0]      jmp_k;
  logic [PC_W-1:0] jmp_target;
  logic            jmp_taken;

  instr_decode u_decode (
    .ir_i     (ir_q),
    .ra_o     (rf_ra),
    .rb_o     (rf_rb),
    .wa_o     (rf_wa),
    .wsel_o   (rf_wsel),
    .alu_fs_o (alu_fs),
    .imm_o    (imm),
    .class_o  (dec_class)
  );

  // Opcode LSB selects the flag polarity that makes the jump taken.
  assign jmp_k      = ir_q[JK_MSB:JK_LSB];
  assign jmp_target = ir_q[JT_MSB:JT_LSB];
  assign jmp_taken  = (f_q[jmp_k] == ir_q[OP_LSB]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      f_q     <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_data;
            pc_q    <= pc_q + PC_W'(1);
            state_q <= S_DECODE;
          end
        end
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          state_q <= S_FETCH;
          case (dec_class)
            CL_ALU, CL_CMP:       f_q <= alu_flag;
            CL_JMP:               if (jmp_taken) pc_q <= jmp_target;
            CL_MEM_LD, CL_MEM_ST: state_q <= S_MEM;
            CL_HLT:               state_q <= S_HALT;
            default:              ;
          endcase
        end
        S_MEM:   if (dmem_ack) state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Strobes are gated by rst so they drop in the same cycle reset is raised,
  // even though the state register already sits in FETCH during reset.
  assign imem_req  = !rst && (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign dmem_req  = !rst && (state_q == S_MEM);
  assign dmem_we   = dmem_req && (dec_class == CL_MEM_ST);
  // Memory loads write back in the ack cycle itself, the only ack-dependent strobe.
  assign rf_we     = !rst &&
                     (((state_q == S_EXEC) &&
                       (dec_class == CL_ALU || dec_class == CL_MOV || dec_class == CL_LD)) ||
                      ((state_q == S_MEM) && (dec_class == CL_MEM_LD) && dmem_ack));
  assign flags     = f_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: the bench plays instruction and data memory
// by hand, driving inputs at the falling edge and checking outputs just after it.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [18:0] imem_data;
  logic [4:0]  rf_ra, rf_rb, rf_wa;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic [7:0]  imm;
  logic [1:0]  alu_fs;
  logic [3:0]  alu_flag;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [3:0]  flags;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .rf_ra     (rf_ra),
    .rf_rb     (rf_rb),
    .rf_wa     (rf_wa),
    .rf_we     (rf_we),
    .rf_wsel   (rf_wsel),
    .imm       (imm),
    .alu_fs    (alu_fs),
    .alu_flag  (alu_flag),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .flags     (flags),
    .halted    (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in a FETCH cycle: answers with zero wait, returns in the DECODE cycle.
  task automatic do_fetch(input logic [18:0] word, input logic [7:0] addr);
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, addr);
    imem_ack  = 1'b1;
    imem_data = word;
    @(negedge clk);
    imem_ack  = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_data = '0; alu_flag = '0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_flags", flags, 0);
    chk("rst_pc", imem_addr, 0);
    chk("rst_ir_ra", rf_ra, 0);
    rst = 1'b0;
    #1;

    // ADD R3,R1,R2
    do_fetch(19'h00C22, 8'h00);
    chk("add_dec_ra", rf_ra, 1);
    chk("add_dec_rb", rf_rb, 2);
    chk("add_dec_we", rf_we, 0);
    chk("add_dec_req", imem_req, 0);
    @(negedge clk); #1;
    chk("add_we", rf_we, 1);
    chk("add_wa", rf_wa, 3);
    chk("add_ra", rf_ra, 1);
    chk("add_rb", rf_rb, 2);
    chk("add_fs", alu_fs, 0);
    chk("add_wsel", rf_wsel, 0);
    alu_flag = 4'b0011;
    @(negedge clk); #1;
    alu_flag = 4'b0000;
    chk("add_flags", flags, 4'b0011);

    // CMP R1,R2 with A>=B, then taken 1001 jump on F[3] to 0x40
    do_fetch(19'h08440, 8'h01);
    @(negedge clk); #1;
    chk("cmp_we", rf_we, 0);
    chk("cmp_fs", alu_fs, 1);
    chk("cmp_ra", rf_ra, 1);
    chk("cmp_rb", rf_rb, 2);
    alu_flag = 4'b1000;
    @(negedge clk); #1;
    alu_flag = 4'b0000;
    chk("cmp_flags", flags, 4'b1000);
    do_fetch(19'h4E800, 8'h02);
    @(negedge clk); #1;
    chk("jmp_we", rf_we, 0);
    alu_flag = 4'b0111;  // a jump must not latch flags
    @(negedge clk); #1;
    alu_flag = 4'b0000;
    chk("jmp_flags", flags, 4'b1000);

    // CMP with flags 0, then the same jump falls through
    do_fetch(19'h08440, 8'h40);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("cmp0_flags", flags, 0);
    do_fetch(19'h4E800, 8'h41);
    @(negedge clk); #1;
    @(negedge clk); #1;
    // 1000 jump on F[3]==0 is taken to 0x10
    do_fetch(19'h46200, 8'h42);
    @(negedge clk); #1;
    @(negedge clk); #1;

    // MOV Ry=1 <- Rx=6
    do_fetch(19'h21820, 8'h10);
    @(negedge clk); #1;
    chk("mov_we", rf_we, 1);
    chk("mov_rb", rf_rb, 6);
    chk("mov_wa", rf_wa, 1);
    chk("mov_wsel", rf_wsel, 3);
    @(negedge clk); #1;

    // Load R4 <- (R5) with three wait cycles
    do_fetch(19'h29480, 8'h11);
    chk("ldm_dec_ra", rf_ra, 5);
    @(negedge clk); #1;
    chk("ldm_exec_we", rf_we, 0);
    chk("ldm_exec_dreq", dmem_req, 0);
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("ldm_dreq", dmem_req, 1);
      chk("ldm_dwe", dmem_we, 0);
      chk("ldm_ra", rf_ra, 5);
      if (i == 3) dmem_ack = 1'b1;
      #1;
      chk("ldm_we", rf_we, (i == 3) ? 1 : 0);
      if (i == 3) begin
        chk("ldm_wa", rf_wa, 4);
        chk("ldm_wsel", rf_wsel, 1);
      end
      @(negedge clk); #1;
    end
    dmem_ack = 1'b0;
    chk("ldm_done_dreq", dmem_req, 0);

    // Store Rx=2 -> (Ry=3), zero wait
    do_fetch(19'h30860, 8'h12);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("stm_dreq", dmem_req, 1);
    chk("stm_dwe", dmem_we, 1);
    chk("stm_ra", rf_ra, 3);
    chk("stm_rb", rf_rb, 2);
    dmem_ack = 1'b1;
    #1;
    chk("stm_we", rf_we, 0);
    @(negedge clk); #1;
    dmem_ack = 1'b0;

    // Jump to 0xFF (F[0]==0, opcode 1000), LD R7,0xA5 there, PC wraps to 0
    do_fetch(19'h41FE0, 8'h13);
    @(negedge clk); #1;
    @(negedge clk); #1;
    do_fetch(19'h39E94, 8'hFF);
    @(negedge clk); #1;
    chk("ldi_we", rf_we, 1);
    chk("ldi_imm", imm, 8'hA5);
    chk("ldi_wsel", rf_wsel, 2);
    chk("ldi_wa", rf_wa, 7);
    @(negedge clk); #1;

    // HLT at address 0
    do_fetch(19'h78000, 8'h00);
    @(negedge clk); #1;
    chk("hlt_exec_we", rf_we, 0);
    @(negedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      chk("hlt_halted", halted, 1);
      chk("hlt_imem_req", imem_req, 0);
      @(negedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("hlt_rst_halted", halted, 0);
    chk("hlt_rst_req", imem_req, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;

    // Build non-zero PC and F, then reset in the middle of a stalled fetch
    do_fetch(19'h00C22, 8'h00);
    @(negedge clk); #1;
    alu_flag = 4'b0101;
    @(negedge clk); #1;
    alu_flag = 4'b0000;
    chk("pre_rst_flags", flags, 4'b0101);
    @(negedge clk); #1;
    chk("stall_req", imem_req, 1);
    chk("stall_addr", imem_addr, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_pc", imem_addr, 0);
    chk("mid_rst_flags", flags, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    do_fetch(19'h00C22, 8'h00);
    chk("restart_dec_ra", rf_ra, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
